req_encoder_8to3: RTL and testbench
===================================

// Module: req_encoder_8to3
// PURPOSE
//  Registered 8-to-3 request encoder; the inverse of the 3-to-8 select decoder.
//  Latches one-hot/multi-hot request lines into a sticky pending register and
//  emits one winning index at a time as a binary code plus a one-hot echo.
//  Each index is held under a valid/ready handshake.
//  Sits between peripheral/request sources and the processor control path,
//  which consumes the index (e.g. as a cause/vector code).
// PARAMETERS
//  NUM_REQ      8   number of request lines (power of two)
//  IDX_W        3   index width, must equal log2(NUM_REQ)
//  ROUND_ROBIN  0   0 = fixed priority (lowest index wins); 1 = rotating priority
// PORTS
//  clk          in   1        rising-edge clock
//  rst          in   1        asynchronous reset, active high
//  req_in       in   NUM_REQ  request pulses/levels, sampled every clk edge
//  mask         in   NUM_REQ  1 = line eligible for selection; pending still latches
//  out_ready    in   1        consumer accepts out_idx this cycle
//  out_valid    out  1        out_idx/out_onehot hold a valid winner
//  out_idx      out  IDX_W    binary index of winner
//  out_onehot   out  NUM_REQ  one-hot of winner; all-zero when !out_valid
//  pending      out  NUM_REQ  current sticky pending register
//  any_pending  out  1        |(pending & mask), combinational from registers
// BEHAVIOUR
//  Reset (async, rst=1): pending=0, out_valid=0, out_idx=0, out_onehot=0,
//   state=IDLE, last_grant=NUM_REQ-1. Outputs stay at reset values while rst=1.
//  Reset mid-HOLD: the in-flight index and all pending bits are discarded.
//  Pending update each edge: pending <= (pending & ~clr) | req_in.
//   clr = out_onehot when (out_valid & out_ready), else 0.
//   Same-bit req_in coincident with its own acceptance: bit stays set
//   (new request wins).
//  Winner selection, combinational over elig = pending & mask:
//   ROUND_ROBIN=0: lowest set index of elig.
//   ROUND_ROBIN=1: first set index scanning from last_grant+1 upward, wrapping
//    NUM_REQ-1 -> 0. last_grant updates on handshake.
//   The first grant after reset therefore searches from index 0.
//  FSM states:
//   IDLE: out_valid=0, out_onehot=0.
//    If elig!=0 at the edge: register the winner into out_idx/out_onehot,
//    set out_valid=1, go to HOLD. Otherwise stay in IDLE.
//   HOLD: out_valid=1; out_idx and out_onehot are frozen.
//    Changes to mask or req_in do not retract or alter the held winner.
//    If out_ready=1 at the edge: clear that pending bit, go to IDLE.
//    Otherwise stay in HOLD.
//  Latency: req_in high at edge k -> pending bit set after k -> out_valid high
//   after edge k+1 (2 edges). One bubble cycle follows each handshake.
//   Peak throughput is therefore 1 index per 2 cycles.
//  out_ready while !out_valid is ignored.
//  Widths: out_idx is exactly IDX_W bits; no truncation paths.
//  mask=0 with pending!=0: stays in IDLE; bits persist until unmasked.
// TESTING
//  1 Reset: rst=1 mid-stream -> out_valid=0, pending=0, out_idx=0 immediately,
//    without waiting for a clk edge.
//  2 Single request: req_in=8'h20 for 1 cycle, mask=8'hFF, out_ready=1
//    -> out_valid after 2 edges, out_idx=5, out_onehot=8'h20; pending=0 after
//    the handshake.
//  3 Fixed priority: req_in=8'h91 once, out_ready=1 -> grants 0, 4, 7 on
//    successive HOLD cycles, each separated by one IDLE cycle.
//  4 Round robin (ROUND_ROBIN=1): hold req_in=8'h05 continuously
//    -> grants alternate 0, 2, 0, 2.
//  5 Backpressure: grant idx 3 with out_ready=0 for 5 cycles while req_in=8'h01
//    -> out_idx stays 3; then grant 0 follows after the handshake.
//  6 Mask: pending=8'h40, mask=8'hBF -> no out_valid; set mask=8'hFF
//    -> out_idx=6 after 1 edge.

Source files
------------

// File: rtl/req_encoder_8to3_if.sv
// Request/grant bundle between request sources, the encoder and the index consumer.
interface req_encoder_8to3_if #(
    parameter int unsigned NUM_REQ = 8,
    parameter int unsigned IDX_W   = 3
) ();
    logic [NUM_REQ-1:0] i_req_in;
    logic [NUM_REQ-1:0] i_mask;
    logic               i_out_ready;
    logic               o_out_valid;
    logic [IDX_W-1:0]   o_out_idx;
    logic [NUM_REQ-1:0] o_out_onehot;
    logic [NUM_REQ-1:0] o_pending;
    logic               o_any_pending_c;

    // Encoder side
    modport master (
        input  i_req_in, i_mask, i_out_ready,
        output o_out_valid, o_out_idx, o_out_onehot, o_pending, o_any_pending_c
    );

    // Source/consumer side
    modport slave (
        output i_req_in, i_mask, i_out_ready,
        input  o_out_valid, o_out_idx, o_out_onehot, o_pending, o_any_pending_c
    );
endinterface

// File: rtl/req_encoder_8to3.sv
// Registered 8-to-3 request encoder: sticky pending bits, one winner at a time
// presented under a valid/ready handshake, fixed or rotating priority.
module req_encoder_8to3 #(
    parameter int unsigned NUM_REQ     = 8,
    parameter int unsigned IDX_W       = 3,
    parameter int unsigned ROUND_ROBIN = 0
) (
    input  logic clk,
    input  logic rst,
    req_encoder_8to3_if.master bus
);
    typedef enum logic {S_IDLE, S_HOLD} state_t;

    state_t             r_state, w_state_nxt;
    logic [NUM_REQ-1:0] r_pending, w_pending_nxt;
    logic [NUM_REQ-1:0] r_onehot, w_onehot_nxt;
    logic [IDX_W-1:0]   r_idx, w_idx_nxt;
    logic [IDX_W-1:0]   r_last_grant, w_last_grant_nxt;
    logic               r_valid, w_valid_nxt;

    logic [NUM_REQ-1:0] w_elig;
    logic [NUM_REQ-1:0] w_clr;
    logic [IDX_W-1:0]   w_winner;
    logic [IDX_W-1:0]   w_cand;
    logic               w_found;
    logic               w_handshake;

    assign w_elig = r_pending & bus.i_mask;

    // Winner search: from index 0, or from the slot after the last grant when rotating
    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        w_cand   = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            if (ROUND_ROBIN != 0)
                w_cand = IDX_W'(r_last_grant + IDX_W'(1) + IDX_W'(k));
            else
                w_cand = IDX_W'(k);
            if (!w_found && w_elig[w_cand]) begin
                w_winner = w_cand;
                w_found  = 1'b1;
            end
        end
    end

    assign w_handshake   = (r_state == S_HOLD) && bus.i_out_ready;
    assign w_clr         = w_handshake ? r_onehot : '0;
    // A request arriving with its own acceptance re-sets the bit
    assign w_pending_nxt = (r_pending & ~w_clr) | bus.i_req_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_pending    <= '0;
            r_valid      <= 1'b0;
            r_idx        <= '0;
            r_onehot     <= '0;
            r_last_grant <= IDX_W'(NUM_REQ - 1);
        end else begin
            r_state      <= w_state_nxt;
            r_pending    <= w_pending_nxt;
            r_valid      <= w_valid_nxt;
            r_idx        <= w_idx_nxt;
            r_onehot     <= w_onehot_nxt;
            r_last_grant <= w_last_grant_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_valid_nxt      = r_valid;
        w_idx_nxt        = r_idx;
        w_onehot_nxt     = r_onehot;
        w_last_grant_nxt = r_last_grant;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt  = S_HOLD;
                    w_valid_nxt  = 1'b1;
                    w_idx_nxt    = w_winner;
                    w_onehot_nxt = NUM_REQ'(1) << w_winner;
                end
            end
            S_HOLD: begin
                if (bus.i_out_ready) begin
                    w_state_nxt      = S_IDLE;
                    w_valid_nxt      = 1'b0;
                    w_onehot_nxt     = '0;
                    w_last_grant_nxt = r_idx;
                end
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_valid_nxt  = 1'b0;
                w_onehot_nxt = '0;
            end
        endcase
    end

    assign bus.o_out_valid     = r_valid;
    assign bus.o_out_idx       = r_idx;
    assign bus.o_out_onehot    = r_onehot;
    assign bus.o_pending       = r_pending;
    assign bus.o_any_pending_c = |(r_pending & bus.i_mask);
endmodule

// File: tb/tb_req_encoder_8to3.sv
// Bench for req_encoder_8to3: fixed-priority and rotating instances driven in
// lockstep, directed scenarios plus random traffic against a reference model.
module tb_req_encoder_8to3;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    req_encoder_8to3_if #(.NUM_REQ(8), .IDX_W(3)) bus_fp ();
    req_encoder_8to3_if #(.NUM_REQ(8), .IDX_W(3)) bus_rr ();

    req_encoder_8to3 #(.NUM_REQ(8), .IDX_W(3), .ROUND_ROBIN(0)) dut_fp (
        .clk(clk), .rst(rst), .bus(bus_fp.master));
    req_encoder_8to3 #(.NUM_REQ(8), .IDX_W(3), .ROUND_ROBIN(1)) dut_rr (
        .clk(clk), .rst(rst), .bus(bus_rr.master));

    // Reference model, index 0 = fixed priority, 1 = round robin
    bit [7:0] m_pend [2];
    bit       m_valid[2];
    int       m_idx  [2];
    int       m_last [2];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_pend[d] = 8'h00; m_valid[d] = 1'b0; m_idx[d] = 0; m_last[d] = 7;
        end
    endtask

    task automatic model_step(input int d, input bit [7:0] req, input bit [7:0] msk, input bit rdy);
        bit [7:0] elig;
        int       win;
        int       i;
        elig = m_pend[d] & msk;
        win  = -1;
        if (!m_valid[d]) begin
            for (int k = 0; k < 8; k++) begin
                i = (d == 1) ? (m_last[d] + 1 + k) % 8 : k;
                if (win < 0 && elig[i]) win = i;
            end
        end
        if (m_valid[d] && rdy) m_pend[d] = m_pend[d] & ~(8'h01 << m_idx[d]);
        m_pend[d] = m_pend[d] | req;
        if (!m_valid[d]) begin
            if (win >= 0) begin m_valid[d] = 1'b1; m_idx[d] = win; end
        end else if (rdy) begin
            m_valid[d] = 1'b0; m_last[d] = m_idx[d];
        end
    endtask

    task automatic get_obs(input int d, output logic v, output logic [2:0] idx,
                           output logic [7:0] oh, output logic [7:0] pend, output logic any);
        if (d == 0) begin
            v = bus_fp.o_out_valid; idx = bus_fp.o_out_idx; oh = bus_fp.o_out_onehot;
            pend = bus_fp.o_pending; any = bus_fp.o_any_pending_c;
        end else begin
            v = bus_rr.o_out_valid; idx = bus_rr.o_out_idx; oh = bus_rr.o_out_onehot;
            pend = bus_rr.o_pending; any = bus_rr.o_any_pending_c;
        end
    endtask

    // One clock: apply inputs, advance the model at the edge, return at the negedge
    task automatic drive(input logic [7:0] req, input logic [7:0] msk, input logic rdy);
        bus_fp.i_req_in = req; bus_fp.i_mask = msk; bus_fp.i_out_ready = rdy;
        bus_rr.i_req_in = req; bus_rr.i_mask = msk; bus_rr.i_out_ready = rdy;
        @(posedge clk);
        model_step(0, req, msk, rdy);
        model_step(1, req, msk, rdy);
        @(negedge clk);
    endtask

    task automatic do_reset();
        bus_fp.i_req_in = '0; bus_fp.i_mask = 8'hFF; bus_fp.i_out_ready = 1'b0;
        bus_rr.i_req_in = '0; bus_rr.i_mask = 8'hFF; bus_rr.i_out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        logic v, any; logic [2:0] idx; logic [7:0] oh, pend;
        do_reset();
        for (int d = 0; d < 2; d++) begin
            get_obs(d, v, idx, oh, pend, any);
            n_checks++;
            if ({v, idx, oh, pend, any} !== 20'h0)
                $display("FAIL reset_state dut%0d: valid=%b idx=%0d onehot=%h pending=%h any=%b, want all zero",
                         d, v, idx, oh, pend, any);
            else n_pass++;
        end
    endtask

    task automatic test_single();
        do_reset();
        drive(8'h20, 8'hFF, 1'b1);
        n_checks++;
        if (bus_fp.o_out_valid !== 1'b0 || bus_fp.o_pending !== 8'h20)
            $display("FAIL single_edge1: valid=%b pending=%h, want 0/20", bus_fp.o_out_valid, bus_fp.o_pending);
        else n_pass++;
        drive(8'h00, 8'hFF, 1'b1);
        n_checks++;
        if (bus_fp.o_out_valid !== 1'b1 || bus_fp.o_out_idx !== 3'd5 || bus_fp.o_out_onehot !== 8'h20)
            $display("FAIL single_grant: valid=%b idx=%0d onehot=%h, want 1/5/20",
                     bus_fp.o_out_valid, bus_fp.o_out_idx, bus_fp.o_out_onehot);
        else n_pass++;
        drive(8'h00, 8'hFF, 1'b1);
        n_checks++;
        if (bus_fp.o_out_valid !== 1'b0 || bus_fp.o_pending !== 8'h00 || bus_fp.o_out_onehot !== 8'h00)
            $display("FAIL single_after_hs: valid=%b pending=%h onehot=%h, want 0/00/00",
                     bus_fp.o_out_valid, bus_fp.o_pending, bus_fp.o_out_onehot);
        else n_pass++;
    endtask

    task automatic test_fixed_prio();
        int exp_idx[3] = '{0, 4, 7};
        do_reset();
        drive(8'h91, 8'hFF, 1'b1);
        for (int c = 1; c <= 6; c++) begin
            drive(8'h00, 8'hFF, 1'b1);
            n_checks++;
            if (bus_fp.o_out_valid !== 1'(c % 2) ||
                (c % 2 == 1 && bus_fp.o_out_idx !== 3'(exp_idx[c / 2])))
                $display("FAIL fixed_prio_c%0d: valid=%b idx=%0d, want valid=%0d idx=%0d",
                         c, bus_fp.o_out_valid, bus_fp.o_out_idx, c % 2, exp_idx[c / 2]);
            else n_pass++;
        end
    endtask

    task automatic test_round_robin();
        int q_rr[$];
        int q_fp[$];
        int exp_rr[4] = '{0, 2, 0, 2};
        do_reset();
        for (int c = 0; c < 8; c++) begin
            drive(8'h05, 8'hFF, 1'b1);
            if (bus_rr.o_out_valid === 1'b1) q_rr.push_back(int'(bus_rr.o_out_idx));
            if (bus_fp.o_out_valid === 1'b1) q_fp.push_back(int'(bus_fp.o_out_idx));
        end
        n_checks++;
        if (q_rr.size() != 4 || q_fp.size() != 4)
            $display("FAIL rr_grant_count: rr=%0d fp=%0d, want 4/4", q_rr.size(), q_fp.size());
        else begin
            n_pass++;
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (q_rr[i] != exp_rr[i] || q_fp[i] != 0)
                    $display("FAIL rr_grant%0d: rr=%0d fp=%0d, want rr=%0d fp=0", i, q_rr[i], q_fp[i], exp_rr[i]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        drive(8'h08, 8'hFF, 1'b0);
        drive(8'h01, 8'hFF, 1'b0);
        for (int c = 0; c < 5; c++) begin
            drive(8'h01, 8'hFF, 1'b0);
            n_checks++;
            if (bus_fp.o_out_valid !== 1'b1 || bus_fp.o_out_idx !== 3'd3 || bus_fp.o_out_onehot !== 8'h08)
                $display("FAIL backpressure_hold%0d: valid=%b idx=%0d onehot=%h, want 1/3/08",
                         c, bus_fp.o_out_valid, bus_fp.o_out_idx, bus_fp.o_out_onehot);
            else n_pass++;
        end
        drive(8'h00, 8'hFF, 1'b1);
        n_checks++;
        if (bus_fp.o_out_valid !== 1'b0 || bus_fp.o_pending !== 8'h01)
            $display("FAIL backpressure_bubble: valid=%b pending=%h, want 0/01", bus_fp.o_out_valid, bus_fp.o_pending);
        else n_pass++;
        drive(8'h00, 8'hFF, 1'b1);
        n_checks++;
        if (bus_fp.o_out_valid !== 1'b1 || bus_fp.o_out_idx !== 3'd0)
            $display("FAIL backpressure_next: valid=%b idx=%0d, want 1/0", bus_fp.o_out_valid, bus_fp.o_out_idx);
        else n_pass++;
    endtask

    task automatic test_mask();
        do_reset();
        drive(8'h40, 8'hBF, 1'b1);
        for (int c = 0; c < 3; c++) begin
            drive(8'h00, 8'hBF, 1'b1);
            n_checks++;
            if (bus_fp.o_out_valid !== 1'b0 || bus_fp.o_pending !== 8'h40 || bus_fp.o_any_pending_c !== 1'b0)
                $display("FAIL mask_blocked%0d: valid=%b pending=%h any=%b, want 0/40/0",
                         c, bus_fp.o_out_valid, bus_fp.o_pending, bus_fp.o_any_pending_c);
            else n_pass++;
        end
        drive(8'h00, 8'hFF, 1'b0);
        n_checks++;
        if (bus_fp.o_out_valid !== 1'b1 || bus_fp.o_out_idx !== 3'd6 || bus_fp.o_any_pending_c !== 1'b1)
            $display("FAIL mask_release: valid=%b idx=%0d any=%b, want 1/6/1",
                     bus_fp.o_out_valid, bus_fp.o_out_idx, bus_fp.o_any_pending_c);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic v, any; logic [2:0] idx; logic [7:0] oh, pend;
        do_reset();
        drive(8'h0C, 8'hFF, 1'b0);
        drive(8'h00, 8'hFF, 1'b0);
        rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            get_obs(d, v, idx, oh, pend, any);
            n_checks++;
            if ({v, idx, oh, pend, any} !== 20'h0)
                $display("FAIL reset_async dut%0d: valid=%b idx=%0d onehot=%h pending=%h any=%b, want all zero",
                         d, v, idx, oh, pend, any);
            else n_pass++;
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        drive(8'h00, 8'hFF, 1'b1);
        drive(8'h00, 8'hFF, 1'b1);
        n_checks++;
        if (bus_fp.o_out_valid !== 1'b0 || bus_fp.o_pending !== 8'h00)
            $display("FAIL reset_discard: valid=%b pending=%h, want 0/00", bus_fp.o_out_valid, bus_fp.o_pending);
        else n_pass++;
    endtask

    task automatic test_random();
        logic v, any; logic [2:0] idx; logic [7:0] oh, pend;
        logic [7:0] req, msk; logic rdy;
        bit [7:0] exp_oh;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            req = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            msk = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
            rdy = ($urandom_range(0, 2) != 0);
            drive(req, msk, rdy);
            for (int d = 0; d < 2; d++) begin
                get_obs(d, v, idx, oh, pend, any);
                exp_oh = m_valid[d] ? (8'h01 << m_idx[d]) : 8'h00;
                n_checks++;
                if (v !== m_valid[d] || oh !== exp_oh || pend !== m_pend[d] ||
                    any !== |(m_pend[d] & msk) || (m_valid[d] && idx !== 3'(m_idx[d])))
                    $display("FAIL random_c%0d_dut%0d: valid=%b idx=%0d onehot=%h pending=%h any=%b, want %b/%0d/%h/%h/%b",
                             c, d, v, idx, oh, pend, any, m_valid[d], m_idx[d], exp_oh, m_pend[d], |(m_pend[d] & msk));
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fixed_prio();
        test_round_robin();
        test_backpressure();
        test_mask();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end
endmodule
